crc_byte_sequencer: RTL

Sequencer that sits between the TinyQV register interface and the byte-wide CRC32 engine. Software programs a message length in bytes, then streams 32-bit words. The block buffers the words in a small FIFO and feeds them to the engine one byte per cycle, LSB first, under a valid/ready handshake. It also issues the engine's init and finish strobes, and raises a completion interrupt once the engine reports done.

---
 rtl/crc_byte_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/crc_byte_sequencer.sv
// Buffers 32-bit words and feeds them LSB-first, one byte per cycle, to a CRC32 engine with init/finish strobes.
// Word-to-byte latency is one cycle (no bypass); eng_ready low stalls the byte stream, and a full FIFO drops wr_ready.
module crc_byte_sequencer #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             wr_valid,
    input  logic [31:0]      wr_data,
    output logic             wr_ready,
    output logic             eng_init,
    output logic             eng_valid,
    output logic [7:0]       eng_byte,
    input  logic             eng_ready,
    output logic             eng_finish,
    input  logic             eng_done,
    output logic             busy,
    output logic [LEN_W-1:0] bytes_left,
    output logic             irq,
    input  logic             irq_clr,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INIT      = 3'd1;
    localparam logic [2:0] S_STREAM    = 3'd2;
    localparam logic [2:0] S_FINISH    = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
    logic [LEN_W:0]   words_left_q, words_left_d;
    logic [1:0]       idx_q, idx_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             irq_q, irq_d;
    logic             err_q, err_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];

    logic        fifo_empty;
    logic        fifo_full;
    logic [31:0] head;
    logic        push;
    logic        hs;
    logic        last_in_word;
    logic        pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // words_left gates writes so the FIFO never holds more words than the message needs
    assign wr_ready   = ((state_q == S_INIT) || (state_q == S_STREAM)) &&
                        !fifo_full && (words_left_q != '0);
    assign eng_valid  = (state_q == S_STREAM) && !fifo_empty;
    assign eng_byte   = eng_valid ? head[{idx_q, 3'b000} +: 8] : 8'h00;
    assign eng_init   = (state_q == S_INIT);
    assign eng_finish = (state_q == S_FINISH);
    assign busy       = (state_q != S_IDLE);
    assign bytes_left = bytes_left_q;
    assign irq        = irq_q;
    assign err        = err_q;

    assign push         = wr_valid && wr_ready;
    assign hs           = eng_valid && eng_ready;
    assign last_in_word = (idx_q == 2'd3) || (bytes_left_q == LEN_W'(1));
    assign pop          = hs && last_in_word;

    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        words_left_d = words_left_q;
        idx_d        = idx_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        irq_d        = irq_q;
        err_d        = err_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d     = wr_ptr_q + (AW+1)'(1);
            words_left_d = words_left_q - (LEN_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (hs) begin
            bytes_left_d = bytes_left_q - LEN_W'(1);
            idx_d        = last_in_word ? 2'd0 : idx_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bytes_left_d = len;
                    words_left_d = ({1'b0, len} + (LEN_W+1)'(3)) >> 2;
                    state_d      = S_INIT;
                    err_d        = 1'b0;
                end
            end
            S_INIT:      state_d = (bytes_left_q != '0) ? S_STREAM : S_FINISH;
            S_STREAM:    if (hs && (bytes_left_q == LEN_W'(1))) state_d = S_FINISH;
            S_FINISH:    state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (eng_done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        if (wr_valid && !wr_ready) begin
            err_d = 1'b1;
        end

        // set beats clear when both land in the same cycle
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if ((state_q == S_WAIT_DONE) && eng_done && !abort) begin
            irq_d = 1'b1;
        end

        if (abort) begin
            state_d      = S_IDLE;
            bytes_left_d = '0;
            words_left_d = '0;
            idx_d        = 2'd0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bytes_left_q <= '0;
            words_left_q <= '0;
            idx_q        <= 2'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            irq_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bytes_left_q <= bytes_left_d;
            words_left_q <= words_left_d;
            idx_q        <= idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            irq_q        <= irq_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
